// File: rtl/pattern_generator_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_pkg
//  Description : Shared constants for the serial pattern generator: state
//                encoding, default pattern, PRBS-7 taps/seed and step function.
//  Revision    : 1.0  initial release
// ============================================================================
package pattern_pkg;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_SHIFT = 2'd1;
    localparam logic [1:0] C_ST_GAP   = 2'd2;
    localparam logic [1:0] C_ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = C_ST_IDLE,
        S_SHIFT = C_ST_SHIFT,
        S_GAP   = C_ST_GAP,
        S_DONE  = C_ST_DONE
    } state_t;

    localparam logic [4:0] C_DEFAULT_PATTERN = 5'b11011;

    // x^7 + x^6 + 1 : feedback from stages 7 and 6
    localparam logic [6:0] C_PRBS_TAPS = 7'b1100000;
    localparam logic [6:0] C_PRBS_SEED = 7'h7F;

    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], ^(s & C_PRBS_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_generator_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_generator_serial_if
//  Description : Job request and serial output bundle of the pattern generator.
//  Revision    : 1.0  initial release
// ============================================================================
interface pattern_generator_serial_if #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start_i;
    logic [PAT_W-1:0] pattern_i;
    logic [CNT_W-1:0] repeat_i;
    logic [GAP_W-1:0] gap_i;
    logic             abort_i;
    logic             ready_o;
    logic             busy_o;
    logic             d_o;
    logic             d_valid_o;
    logic             pattern_end_o;
    logic             done_o;

    modport master (
        output start_i, pattern_i, repeat_i, gap_i, abort_i,
        input  ready_o, busy_o, d_o, d_valid_o, pattern_end_o, done_o
    );

    modport slave (
        input  start_i, pattern_i, repeat_i, gap_i, abort_i,
        output ready_o, busy_o, d_o, d_valid_o, pattern_end_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/pattern_generator_serial_prbs7_gen.sv
`default_nettype none
// ============================================================================
//  Module      : prbs7_gen
//  Description : PRBS-7 source (x^7+x^6+1) with seed reload and step enable.
//  Revision    : 1.0  initial release
// ============================================================================
module prbs7_gen
    import pattern_pkg::*;
(
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic en_i,
    input  wire logic load_i,
    output logic      bit_o
);
    logic [6:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr_q <= C_PRBS_SEED;
        end else if (load_i) begin
            lfsr_q <= C_PRBS_SEED;
        end else if (en_i) begin
            lfsr_q <= prbs7_next(lfsr_q);
        end
    end

    assign bit_o = lfsr_q[6];
endmodule
`default_nettype wire

// File: rtl/pattern_generator_serial.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_generator_serial
//  Description : Emits a PAT_W-bit pattern MSB-first, repeated N times with an
//                optional idle gap. PATTERN_GEN_PRBS_EN puts PRBS-7 on d_o in gaps.
//  Revision    : 1.0  initial release
// ============================================================================
module pattern_generator_serial
    import pattern_pkg::*;
#(
    parameter int               PAT_W       = 5,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(C_DEFAULT_PATTERN),
    parameter int               CNT_W       = 8,
    parameter int               GAP_W       = 4
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    pattern_generator_serial_if.slave  bus
);
    localparam int BIT_W = $clog2(PAT_W);

    state_t             state_q;
    logic [PAT_W-1:0]   pat_q;
    logic [PAT_W-1:0]   sh_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   rep_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               ready_q;
    logic               busy_q;
    logic               d_q;
    logic               d_valid_q;
    logic               pend_q;
    logic               done_q;

    logic [PAT_W-1:0]   w_pat_sel;
    logic               w_last_bit;
    logic               w_more;
    logic               w_gap_bit;

    assign w_pat_sel  = (bus.pattern_i == '0) ? PAT_DEFAULT : bus.pattern_i;
    assign w_last_bit = (bit_cnt_q == BIT_W'(PAT_W - 1));
    assign w_more     = (rep_q != CNT_W'(1));

`ifdef PATTERN_GEN_PRBS_EN
    logic w_prbs_en;
    logic w_prbs_load;

    // Step once for every gap cycle: on entry to GAP and on each GAP cycle that stays in GAP
    assign w_prbs_en = !bus.abort_i &&
                       (((state_q == S_SHIFT) && w_last_bit && w_more && (gap_q != '0)) ||
                        ((state_q == S_GAP) && (gap_cnt_q != GAP_W'(1))));
    assign w_prbs_load = (state_q == S_IDLE) && bus.start_i;

    prbs7_gen u_prbs7_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (w_prbs_en),
        .load_i (w_prbs_load),
        .bit_o  (w_gap_bit)
    );
`else
    assign w_gap_bit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            d_q       <= 1'b0;
            d_valid_q <= 1'b0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            pend_q <= 1'b0;
            if (bus.abort_i && (state_q != S_IDLE)) begin
                state_q   <= S_IDLE;
                ready_q   <= 1'b1;
                busy_q    <= 1'b0;
                d_q       <= 1'b0;
                d_valid_q <= 1'b0;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start_i) begin
                            pat_q     <= w_pat_sel;
                            rep_q     <= bus.repeat_i;
                            gap_q     <= bus.gap_i;
                            bit_cnt_q <= '0;
                            ready_q   <= 1'b0;
                            busy_q    <= 1'b1;
                            if (bus.repeat_i == '0) begin
                                state_q   <= S_DONE;
                                done_q    <= 1'b1;
                                d_q       <= 1'b0;
                                d_valid_q <= 1'b0;
                            end else begin
                                state_q   <= S_SHIFT;
                                d_q       <= w_pat_sel[PAT_W-1];
                                sh_q      <= {w_pat_sel[PAT_W-2:0], 1'b0};
                                d_valid_q <= 1'b1;
                            end
                        end
                    end
                    S_SHIFT: begin
                        if (w_last_bit) begin
                            rep_q     <= rep_q - 1'b1;
                            bit_cnt_q <= '0;
                            if (!w_more) begin
                                state_q   <= S_DONE;
                                done_q    <= 1'b1;
                                d_q       <= 1'b0;
                                d_valid_q <= 1'b0;
                            end else if (gap_q == '0) begin
                                // Back-to-back copy: next MSB follows the LSB with no bubble
                                d_q  <= pat_q[PAT_W-1];
                                sh_q <= {pat_q[PAT_W-2:0], 1'b0};
                            end else begin
                                state_q   <= S_GAP;
                                gap_cnt_q <= gap_q;
                                d_q       <= w_gap_bit;
                                d_valid_q <= 1'b0;
                            end
                        end else begin
                            d_q       <= sh_q[PAT_W-1];
                            sh_q      <= {sh_q[PAT_W-2:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            pend_q    <= (bit_cnt_q == BIT_W'(PAT_W - 2));
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt_q == GAP_W'(1)) begin
                            state_q   <= S_SHIFT;
                            d_q       <= pat_q[PAT_W-1];
                            sh_q      <= {pat_q[PAT_W-2:0], 1'b0};
                            d_valid_q <= 1'b1;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - 1'b1;
                            d_q       <= w_gap_bit;
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        d_q       <= 1'b0;
                        d_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ready_o       = ready_q;
    assign bus.busy_o        = busy_q;
    assign bus.d_o           = d_q;
    assign bus.d_valid_o     = d_valid_q;
    assign bus.pattern_end_o = pend_q;
    assign bus.done_o        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_generator_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_generator_serial
//  Description : Self-checking bench; expected serial bits are queued per job.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pattern_generator_serial;
    localparam int PAT_W = 5;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pattern_generator_serial_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    pattern_generator_serial #(
        .PAT_W       (PAT_W),
        .PAT_DEFAULT (5'b11011),
        .CNT_W       (CNT_W),
        .GAP_W       (GAP_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic d;
        logic pend;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         det    = 0;
    logic [4:0] hist   = '0;

`ifdef PATTERN_GEN_PRBS_EN
    localparam logic GAP_BIT = 1'b1;
`else
    localparam logic GAP_BIT = 1'b0;
`endif

    task automatic push_job(input logic [PAT_W-1:0] pat, input int copies);
        logic [PAT_W-1:0] p;
        exp_t e;
        p = (pat == '0) ? 5'b11011 : pat;
        for (int c = 0; c < copies; c++) begin
            for (int b = PAT_W - 1; b >= 0; b--) begin
                e.d    = p[b];
                e.pend = (b == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    // Advance to the next falling edge and score any valid bit against the queue.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (bus.d_valid_o === 1'b1) begin
            hist = {hist[3:0], bus.d_o};
            if (hist == 5'b11011) det++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bit: got d_o=%b with d_valid_o=1, required no valid bit", bus.d_o);
            end else begin
                e = exp_q.pop_front();
                if ({bus.d_o, bus.pattern_end_o} !== {e.d, e.pend}) begin
                    errors++;
                    $display("FAIL serial_bit: got d_o/pattern_end_o=%b%b, required %b%b",
                             bus.d_o, bus.pattern_end_o, e.d, e.pend);
                end
            end
        end
    endtask

    // Drive one request; returns sampled in cycle 1 after the accepting edge.
    task automatic start_job(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep,
                             input logic [GAP_W-1:0] gap, input logic ab);
        bus.pattern_i = pat;
        bus.repeat_i  = rep;
        bus.gap_i     = gap;
        bus.abort_i   = ab;
        bus.start_i   = 1'b1;
        step();
        bus.start_i   = 1'b0;
        bus.abort_i   = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({bus.ready_o, bus.busy_o, bus.d_o, bus.d_valid_o, bus.pattern_end_o, bus.done_o} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_values: got %b, required 100000",
                     {bus.ready_o, bus.busy_o, bus.d_o, bus.d_valid_o, bus.pattern_end_o, bus.done_o});
        end
        rst_n = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready_o, bus.busy_o, bus.d_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_idle: got ready/busy/valid=%b, required 100",
                     {bus.ready_o, bus.busy_o, bus.d_valid_o});
        end
        step();
        rst_n = 1'b1;
        step();
        push_job(5'b11011, 3);
        start_job(5'b11011, 8'd3, 4'd0, 1'b0);
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready_o, bus.busy_o, bus.d_o, bus.d_valid_o, bus.pattern_end_o, bus.done_o} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_mid_shift: got %b, required 100000",
                     {bus.ready_o, bus.busy_o, bus.d_o, bus.d_valid_o, bus.pattern_end_o, bus.done_o});
        end
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus.ready_o, bus.d_valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got ready/valid=%b, required 10", {bus.ready_o, bus.d_valid_o});
        end
    endtask

    task automatic test_single();
        push_job(5'b11011, 1);
        start_job(5'b11011, 8'd1, 4'd0, 1'b0);
        checks++;
        if ({bus.ready_o, bus.busy_o, bus.d_valid_o} !== 3'b011) begin
            errors++;
            $display("FAIL single_latency: got ready/busy/valid=%b, required 011",
                     {bus.ready_o, bus.busy_o, bus.d_valid_o});
        end
        repeat (4) step();
        step();
        checks++;
        if ({bus.done_o, bus.d_valid_o, bus.ready_o, bus.d_o} !== 4'b1000) begin
            errors++;
            $display("FAIL single_done: got done/valid/ready/d=%b, required 1000",
                     {bus.done_o, bus.d_valid_o, bus.ready_o, bus.d_o});
        end
        step();
        checks++;
        if ({bus.ready_o, bus.done_o} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready: got ready/done=%b, required 10", {bus.ready_o, bus.done_o});
        end
    endtask

    task automatic test_default_repeat();
        int d0;
        hist = '0;
        d0 = det;
        push_job(5'b00000, 2);
        start_job(5'b00000, 8'd2, 4'd0, 1'b0);
        repeat (9) step();
        step();
        checks++;
        if ({bus.done_o, bus.d_valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL default_done: got done/valid=%b, required 10", {bus.done_o, bus.d_valid_o});
        end
        step();
        checks++;
        if (det - d0 !== 2) begin
            errors++;
            $display("FAIL default_detections: got %0d, required 2", det - d0);
        end
    endtask

    task automatic test_gap();
        push_job(5'b10101, 2);
        start_job(5'b10101, 8'd2, 4'd3, 1'b0);
        repeat (4) step();
        for (int g = 0; g < 3; g++) begin
            step();
            checks++;
            if ({bus.d_valid_o, bus.d_o, bus.busy_o} !== {1'b0, GAP_BIT, 1'b1}) begin
                errors++;
                $display("FAIL gap_cycle%0d: got valid/d/busy=%b, required %b",
                         g, {bus.d_valid_o, bus.d_o, bus.busy_o}, {1'b0, GAP_BIT, 1'b1});
            end
        end
        repeat (5) step();
        step();
        checks++;
        if ({bus.done_o, bus.d_valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL gap_done: got done/valid=%b, required 10", {bus.done_o, bus.d_valid_o});
        end
        step();
    endtask

    task automatic test_abort_busy_start();
        exp_t e;
        e = '{d: 1'b1, pend: 1'b0}; exp_q.push_back(e);
        e = '{d: 1'b1, pend: 1'b0}; exp_q.push_back(e);
        e = '{d: 1'b0, pend: 1'b0}; exp_q.push_back(e);
        start_job(5'b11001, 8'd4, 4'd0, 1'b0);
        bus.pattern_i = 5'b00111;
        bus.repeat_i  = 8'd1;
        bus.start_i   = 1'b1;
        step();
        step();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        checks++;
        if ({bus.d_valid_o, bus.d_o, bus.done_o, bus.ready_o} !== 4'b0001) begin
            errors++;
            $display("FAIL abort_stop: got valid/d/done/ready=%b, required 0001",
                     {bus.d_valid_o, bus.d_o, bus.done_o, bus.ready_o});
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus.done_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: got done_o=%b, required 0", bus.done_o);
            end
        end
    endtask

    task automatic test_start_abort_idle();
        push_job(5'b10011, 1);
        start_job(5'b10011, 8'd1, 4'd0, 1'b1);
        repeat (4) step();
        step();
        checks++;
        if (bus.done_o !== 1'b1) begin
            errors++;
            $display("FAIL start_wins_done: got done_o=%b, required 1", bus.done_o);
        end
        step();
    endtask

    task automatic test_zero_repeat();
        start_job(5'b11011, 8'd0, 4'd2, 1'b0);
        checks++;
        if ({bus.done_o, bus.d_valid_o, bus.ready_o, bus.busy_o} !== 4'b1001) begin
            errors++;
            $display("FAIL zero_repeat_done: got done/valid/ready/busy=%b, required 1001",
                     {bus.done_o, bus.d_valid_o, bus.ready_o, bus.busy_o});
        end
        step();
        checks++;
        if ({bus.done_o, bus.ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL zero_repeat_ready: got done/ready=%b, required 01", {bus.done_o, bus.ready_o});
        end
    endtask

    initial begin
        bus.start_i   = 1'b0;
        bus.pattern_i = '0;
        bus.repeat_i  = '0;
        bus.gap_i     = '0;
        bus.abort_i   = 1'b0;
        test_reset();
        test_single();
        test_default_repeat();
        test_gap();
        test_abort_busy_start();
        test_start_abort_idle();
        test_zero_repeat();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL bits_outstanding: got %0d queued bits left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
